// File: rtl/decode_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch valid/ready push side, pipeline
// control strobes, and the decode-stage register view.
interface decode_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [XLEN-1:0]              in_pc;
  logic [31:0]                  in_instr;
  logic                         in_misaligned;
  logic                         hold;
  logic                         bubble;
  logic                         flush;
  logic                         dec_valid;
  logic [31:0]                  dec_instr;
  logic [XLEN-1:0]              dec_pc;
  logic                         dec_misaligned;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, in_misaligned, hold, bubble, flush,
    input  in_ready, dec_valid, dec_instr, dec_pc, dec_misaligned, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_misaligned, hold, bubble, flush,
    output in_ready, dec_valid, dec_instr, dec_pc, dec_misaligned, count
  );
endinterface

// File: rtl/decode_fetch_queue.sv
// Instruction queue between fetch and the decode register; the decode register
// keeps hold / bubble / discard behaviour while fetch may run ahead.
module decode_fetch_queue #(
  parameter int          XLEN  = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000033
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_fetch_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_FLUSH   = 2'd0,
    MODE_BUBBLE  = 2'd1,
    MODE_HOLD    = 2'd2,
    MODE_ADVANCE = 2'd3
  } mode_e;

  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [31:0]     instr_mem_r [DEPTH];
  logic            mis_mem_r   [DEPTH];

  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  logic            dec_valid_r;
  logic [31:0]     dec_instr_r;
  logic [XLEN-1:0] dec_pc_r;
  logic            dec_mis_r;

  mode_e           mode_s;
  logic            empty_s;
  logic            in_ready_s;
  logic            push_s;
  logic            wr_en_s;
  logic            pop_s;
  logic            bypass_s;
  logic            dec_kill_s;

  // Control priority: flush beats bubble beats hold; otherwise the pipe advances.
  always_comb begin
    mode_s = MODE_ADVANCE;
    if (bus.flush) begin
      mode_s = MODE_FLUSH;
    end else if (bus.bubble) begin
      mode_s = MODE_BUBBLE;
    end else if (bus.hold) begin
      mode_s = MODE_HOLD;
    end else begin
      mode_s = MODE_ADVANCE;
    end
  end

  // Queue/decode-register actions for this cycle; a full queue refuses pushes even while popping.
  always_comb begin
    empty_s    = (count_r == {CW{1'b0}});
    in_ready_s = !bus.flush && (count_r < CW'(DEPTH));
    push_s     = bus.in_valid && in_ready_s;
    wr_en_s    = 1'b0;
    pop_s      = 1'b0;
    bypass_s   = 1'b0;
    dec_kill_s = 1'b0;
    case (mode_s)
      MODE_FLUSH: begin
        dec_kill_s = 1'b1;
      end
      MODE_BUBBLE: begin
        dec_kill_s = 1'b1;
        wr_en_s    = push_s;
      end
      MODE_HOLD: begin
        wr_en_s = push_s;
      end
      MODE_ADVANCE: begin
        if (!empty_s) begin
          // Queued entries always go first so the bypass can never overtake them.
          pop_s   = 1'b1;
          wr_en_s = push_s;
        end else if (push_s) begin
          bypass_s = 1'b1;
        end else begin
          dec_kill_s = 1'b1;
        end
      end
      default: begin
        dec_kill_s = 1'b1;
      end
    endcase
  end

  // Read/write pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (mode_s == MODE_FLUSH) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pc_mem_r[wr_ptr_r]    <= bus.in_pc;
      instr_mem_r[wr_ptr_r] <= bus.in_instr;
      mis_mem_r[wr_ptr_r]   <= bus.in_misaligned;
    end
  end

  // Decode register: load from queue head or bypass, inject NOP on kill, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_r <= 1'b0;
      dec_instr_r <= NOP;
      dec_pc_r    <= {XLEN{1'b0}};
      dec_mis_r   <= 1'b0;
    end else if (pop_s) begin
      dec_valid_r <= 1'b1;
      dec_instr_r <= instr_mem_r[rd_ptr_r];
      dec_pc_r    <= pc_mem_r[rd_ptr_r];
      dec_mis_r   <= mis_mem_r[rd_ptr_r];
    end else if (bypass_s) begin
      dec_valid_r <= 1'b1;
      dec_instr_r <= bus.in_instr;
      dec_pc_r    <= bus.in_pc;
      dec_mis_r   <= bus.in_misaligned;
    end else if (dec_kill_s) begin
      dec_valid_r <= 1'b0;
      dec_instr_r <= NOP;
      dec_pc_r    <= dec_pc_r;
      dec_mis_r   <= dec_mis_r;
    end else begin
      dec_valid_r <= dec_valid_r;
      dec_instr_r <= dec_instr_r;
      dec_pc_r    <= dec_pc_r;
      dec_mis_r   <= dec_mis_r;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.dec_valid      = dec_valid_r;
  assign bus.dec_instr      = dec_instr_r;
  assign bus.dec_pc         = dec_pc_r;
  assign bus.dec_misaligned = dec_mis_r;
  assign bus.count          = count_r;

endmodule

// File: doc/decode_fetch_queue.md
Name: decode_fetch_queue

Overview:
- Parametrised successor to the fetch-to-decode pipeline register.
- Adds a DEPTH-entry instruction queue between fetch and the decode register, with a valid/ready handshake toward fetch.
- The decode register keeps the existing hold / bubble / discard semantics, so fetch can run ahead during memory stalls instead of freezing.
- Feeds the instruction decoder with {pc, instr, misaligned} plus a valid flag.

Parameters:
- XLEN, 32, width of pc fields.
- DEPTH, 4, queue entries; power of two, at least 2.
- NOP, 32'h00000033, instruction injected on bubble/flush/empty (add x0,x0,x0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue accepts; push = in_valid & in_ready.
- in_pc  in  XLEN  pc of fetched instruction.
- in_instr  in  32  fetched instruction word.
- in_misaligned  in  1  instruction-address-misaligned flag from fetch.
- hold  in  1  memory stall: freeze decode register, no pop.
- bubble  in  1  load-use stall: inject NOP into decode, no pop.
- flush  in  1  discard: empty queue, inject NOP into decode.
- dec_valid  out  1  decode register holds a real instruction.
- dec_instr  out  32  decode-stage instruction.
- dec_pc  out  XLEN  decode-stage pc.
- dec_misaligned  out  1  decode-stage misaligned flag.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=1 at an edge): count=0, read/write pointers=0, dec_instr=NOP, dec_pc=0, dec_misaligned=0, dec_valid=0. Reset overrides every other input, including mid-operation.
- in_ready = !flush && (count < DEPTH). It is combinational and does not depend on in_valid.
- A full queue refuses a push even in a cycle that pops.
- Priority per cycle: rst > flush > bubble > hold > advance.
- flush:
  - pointers and count go to 0; any push this cycle is lost (in_ready=0).
  - dec_instr=NOP, dec_valid=0; dec_pc and dec_misaligned hold.
- bubble:
  - dec_instr=NOP, dec_valid=0; dec_pc and dec_misaligned hold.
  - No pop; a push is accepted if in_ready.
- hold:
  - all dec_* registers hold; no pop; a push is accepted if in_ready.
- advance, queue non-empty:
  - pop the head into dec_*; dec_valid=1.
  - A simultaneous push writes the tail, so count is unchanged.
- advance, queue empty and push:
  - bypass: in_* loads directly into dec_* in the next cycle (1-cycle latency, same as the plain pipeline register); dec_valid=1; count stays 0.
- advance, queue empty and no push:
  - dec_instr=NOP, dec_valid=0; dec_pc holds.
- Pointers wrap modulo DEPTH. Order is strictly FIFO, and the bypass never overtakes queued entries.
- count changes by at most ±1 per cycle, except flush/reset which set it to 0.
- Storage is uninitialised RAM/flops; only pointers, count and dec_* are reset.

Test Plan:
- Reset, then push in_instr=0x00500093, in_pc=0x100 with no control -> next cycle dec_instr=0x00500093, dec_pc=0x100, dec_valid=1, count=0.
- hold high 6 cycles with in_valid each cycle (DEPTH=4):
  - count goes 1,2,3,4,4,4; in_ready=0 once count=4; dec_* unchanged.
  - Release hold -> entries appear in push order, one per cycle.
- count=2, bubble for 1 cycle with a push -> dec_instr=0x33, dec_valid=0, dec_pc unchanged, count=3; next cycle the oldest entry pops.
- count=3, flush with in_valid=1 -> in_ready=0 that cycle; next cycle count=0, dec_instr=0x33, dec_valid=0; the pushed word never appears.
- Stream 10 instructions (pc 0x0..0x24) through DEPTH=4 with random hold pulses -> dec_pc sequence exactly 0x0,0x4,…,0x24, no duplicates, pointers wrap.
- count=2 with hold and flush both high, rst=1 -> next cycle count=0, dec_instr=0x33, dec_pc=0, dec_misaligned=0, dec_valid=0.
